// File: rtl/pcie_us_msi_gen_pkg.sv
// rtl/pcie_us_msi_gen_pkg.sv - shared types, constants and helpers for the MSI generator
//
// Purpose: state encoding, vector-space size and the mmenable clamp shared by
// the MSI generator top level and its round-robin selector.
// Ports: none (package).

package pcie_us_msi_gen_pkg;

    localparam int MSI_VEC_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_BACKOFF = 2'd3
    } msi_state_e;

    // The hard block can grant at most 32 vectors (log2 = 5); larger codes
    // are reserved encodings and are treated as the maximum.
    function automatic logic [2:0] clamp_mmenable(input logic [2:0] mm);
        return (mm > 3'd5) ? 3'd5 : mm;
    endfunction

endpackage

// File: rtl/pcie_us_msi_rr_sel.sv
// rtl/pcie_us_msi_rr_sel.sv - combinational 32-bit round-robin selector
//
// Purpose: pick the lowest set request index at or above the pointer,
// wrapping to the lowest set index overall when none is found.
// Ports:
//   req_i   - request mask, one bit per vector
//   ptr_i   - round-robin start index
//   valid_o - at least one request is set
//   idx_o   - selected vector index

module pcie_us_msi_rr_sel
    import pcie_us_msi_gen_pkg::*;
(
    input  logic [MSI_VEC_MAX-1:0] req_i,
    input  logic [4:0]             ptr_i,
    output logic                   valid_o,
    output logic [4:0]             idx_o
);

    logic       hi_found;
    logic       lo_found;
    logic [4:0] hi_idx;
    logic [4:0] lo_idx;

    // Scanning downwards leaves the lowest matching index in each result.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = 5'd0;
        lo_idx   = 5'd0;
        for (int i = MSI_VEC_MAX - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_found = 1'b1;
                lo_idx   = 5'(i);
                if (i >= int'(ptr_i)) begin
                    hi_found = 1'b1;
                    hi_idx   = 5'(i);
                end
            end
        end
    end

    assign valid_o = lo_found;
    assign idx_o   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/pcie_us_msi_gen.sv
// rtl/pcie_us_msi_gen.sv - MSI interrupt generator for the PCIe hard block, PF0
//
// Purpose: latch interrupt request pulses, fold them onto the granted vector
// count, arbitrate round-robin and issue one-hot MSI pulses, retrying after
// a failure or a response timeout.
// Ports:
//   clk_i, rst_n_i                      - user clock, synchronous active-low reset
//   irq_i                               - per-source request pulses
//   cfg_interrupt_msi_enable_i          - bit 0: PF0 MSI enabled
//   cfg_interrupt_msi_mmenable_i        - bits [2:0]: log2 of granted vector count
//   cfg_interrupt_msi_int_o             - one-hot issue pulse
//   cfg_interrupt_msi_sent_i / _fail_i  - completion / failure pulses
//   cfg_interrupt_msi_*_o (others)      - tied to 0
//   pending_o                           - pending vector bitmap
//   busy_o                              - high in ISSUE, WAIT or BACKOFF

module pcie_us_msi_gen
    import pcie_us_msi_gen_pkg::*;
#(
    parameter int IRQ_COUNT = 32,
    parameter int TIMEOUT   = 4096,
    parameter int BACKOFF   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [IRQ_COUNT-1:0] irq_i,
    input  logic [3:0]           cfg_interrupt_msi_enable_i,
    input  logic [11:0]          cfg_interrupt_msi_mmenable_i,
    output logic [31:0]          cfg_interrupt_msi_int_o,
    input  logic                 cfg_interrupt_msi_sent_i,
    input  logic                 cfg_interrupt_msi_fail_i,
    output logic [3:0]           cfg_interrupt_msi_select_o,
    output logic [3:0]           cfg_interrupt_msi_function_number_o,
    output logic [2:0]           cfg_interrupt_msi_attr_o,
    output logic                 cfg_interrupt_msi_tph_present_o,
    output logic [1:0]           cfg_interrupt_msi_tph_type_o,
    output logic [8:0]           cfg_interrupt_msi_tph_st_tag_o,
    output logic [31:0]          cfg_interrupt_msi_pending_status_o,
    output logic                 cfg_interrupt_msi_pending_status_data_enable_o,
    output logic [3:0]           cfg_interrupt_msi_pending_status_function_num_o,
    output logic [31:0]          pending_o,
    output logic                 busy_o
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int BO_W = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);
    localparam logic [BO_W-1:0] BO_LOAD = BO_W'(BACKOFF - 1);

    msi_state_e              state_q, state_d;
    logic [MSI_VEC_MAX-1:0]  pending_q, pending_d;
    logic [MSI_VEC_MAX-1:0]  msi_int_q, msi_int_d;
    logic [4:0]              ptr_q, ptr_d;
    logic [4:0]              cur_q, cur_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic [BO_W-1:0]         bo_cnt_q, bo_cnt_d;
    logic                    en_q;

    logic [2:0]              mm_log2;
    logic [4:0]              vec_mask;
    logic [MSI_VEC_MAX-1:0]  set_vec;
    logic [MSI_VEC_MAX-1:0]  in_range;
    logic [MSI_VEC_MAX-1:0]  eligible;
    logic                    sel_valid;
    logic [4:0]              sel_idx;
    logic                    unused_cfg;

    assign unused_cfg = ^{cfg_interrupt_msi_enable_i[3:1], cfg_interrupt_msi_mmenable_i[11:3]};

    // Fold sources onto the granted vector space; vector j is in range
    // exactly when it has no bits outside the fold mask.
    always_comb begin
        mm_log2  = clamp_mmenable(cfg_interrupt_msi_mmenable_i[2:0]);
        vec_mask = 5'((6'd1 << mm_log2) - 6'd1);
        set_vec  = '0;
        for (int i = 0; i < IRQ_COUNT; i++) begin
            if (irq_i[i]) begin
                set_vec[5'(i) & vec_mask] = 1'b1;
            end
        end
        for (int j = 0; j < MSI_VEC_MAX; j++) begin
            in_range[j] = ((5'(j) & ~vec_mask) == 5'd0);
        end
        eligible = pending_q & in_range & {MSI_VEC_MAX{en_q}};
    end

    pcie_us_msi_rr_sel u_rr_sel (
        .req_i   (eligible),
        .ptr_i   (ptr_q),
        .valid_o (sel_valid),
        .idx_o   (sel_idx)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | set_vec;
        msi_int_d = '0;
        ptr_d     = ptr_q;
        cur_d     = cur_q;
        to_cnt_d  = to_cnt_q;
        bo_cnt_d  = bo_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    cur_d              = sel_idx;
                    // A request landing in the same cycle as the clear keeps the bit set.
                    pending_d[sel_idx] = set_vec[sel_idx];
                    // Registered here so the pulse is visible during the ISSUE cycle.
                    msi_int_d          = MSI_VEC_MAX'(1) << sel_idx;
                    state_d            = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                to_cnt_d = TO_LOAD;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (cfg_interrupt_msi_fail_i || (to_cnt_q == '0)) begin
                    pending_d[cur_q] = 1'b1;
                    bo_cnt_d         = BO_LOAD;
                    state_d          = ST_BACKOFF;
                end else if (cfg_interrupt_msi_sent_i) begin
                    ptr_d   = cur_q + 5'd1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                end
            end
            ST_BACKOFF: begin
                if (bo_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    bo_cnt_d = bo_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            msi_int_q <= '0;
            ptr_q     <= 5'd0;
            cur_q     <= 5'd0;
            to_cnt_q  <= '0;
            bo_cnt_q  <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            msi_int_q <= msi_int_d;
            ptr_q     <= ptr_d;
            cur_q     <= cur_d;
            to_cnt_q  <= to_cnt_d;
            bo_cnt_q  <= bo_cnt_d;
            // Registered so an enable change takes effect with the same
            // two-cycle latency as a fresh request.
            en_q      <= cfg_interrupt_msi_enable_i[0];
        end
    end

    assign cfg_interrupt_msi_int_o = msi_int_q;
    assign pending_o               = pending_q;
    assign busy_o                  = (state_q != ST_IDLE);

    assign cfg_interrupt_msi_select_o                      = 4'd0;
    assign cfg_interrupt_msi_function_number_o             = 4'd0;
    assign cfg_interrupt_msi_attr_o                        = 3'd0;
    assign cfg_interrupt_msi_tph_present_o                 = 1'b0;
    assign cfg_interrupt_msi_tph_type_o                    = 2'd0;
    assign cfg_interrupt_msi_tph_st_tag_o                  = 9'd0;
    assign cfg_interrupt_msi_pending_status_o              = 32'd0;
    assign cfg_interrupt_msi_pending_status_data_enable_o  = 1'b0;
    assign cfg_interrupt_msi_pending_status_function_num_o = 4'd0;

endmodule

// File: tb/tb_pcie_us_msi_gen.sv
// tb/tb_pcie_us_msi_gen.sv - directed self-checking bench for pcie_us_msi_gen

module tb_pcie_us_msi_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] irq = '0;
    logic [3:0]  en = 4'd1;
    logic [11:0] mmen = 12'd5;
    logic        sent = 1'b0;
    logic        fail = 1'b0;
    logic [31:0] msi_int;
    logic [3:0]  sel_o, fn_o, ps_fn_o;
    logic [2:0]  attr_o;
    logic        tph_p_o, ps_de_o;
    logic [1:0]  tph_t_o;
    logic [8:0]  tph_tag_o;
    logic [31:0] ps_o;
    logic [31:0] pending;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    pcie_us_msi_gen #(.IRQ_COUNT(32), .TIMEOUT(64), .BACKOFF(16)) dut (
        .clk_i                                          (clk),
        .rst_n_i                                        (rst_n),
        .irq_i                                          (irq),
        .cfg_interrupt_msi_enable_i                     (en),
        .cfg_interrupt_msi_mmenable_i                   (mmen),
        .cfg_interrupt_msi_int_o                        (msi_int),
        .cfg_interrupt_msi_sent_i                       (sent),
        .cfg_interrupt_msi_fail_i                       (fail),
        .cfg_interrupt_msi_select_o                     (sel_o),
        .cfg_interrupt_msi_function_number_o            (fn_o),
        .cfg_interrupt_msi_attr_o                       (attr_o),
        .cfg_interrupt_msi_tph_present_o                (tph_p_o),
        .cfg_interrupt_msi_tph_type_o                   (tph_t_o),
        .cfg_interrupt_msi_tph_st_tag_o                 (tph_tag_o),
        .cfg_interrupt_msi_pending_status_o             (ps_o),
        .cfg_interrupt_msi_pending_status_data_enable_o (ps_de_o),
        .cfg_interrupt_msi_pending_status_function_num_o(ps_fn_o),
        .pending_o                                      (pending),
        .busy_o                                         (busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_msi(input int budget, output logic [31:0] v, output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (msi_int === 32'd0 && n < budget);
        v  = msi_int;
        at = cyc_cnt;
    endtask

    task automatic ack_sent();
        tick();
        sent = 1'b1;
        tick();
        sent = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (msi_int !== 32'd0) begin n_err++; $display("FAIL reset_msi_int got=%h exp=0", msi_int); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++;
        if (pending !== 32'd0) begin n_err++; $display("FAIL reset_pending got=%h exp=0", pending); end
        n_vec++;
        if ({sel_o, fn_o, attr_o, tph_p_o, tph_t_o, tph_tag_o, ps_o, ps_de_o, ps_fn_o} !== 62'd0) begin
            n_err++;
            $display("FAIL const_outputs got=%h exp=0",
                     {sel_o, fn_o, attr_o, tph_p_o, tph_t_o, tph_tag_o, ps_o, ps_de_o, ps_fn_o});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] v;
        int a;
        mmen = 12'd5;
        irq  = 32'h8;
        tick();
        irq = '0;
        n_vec++;
        if (pending !== 32'h8) begin n_err++; $display("FAIL basic_pending_set got=%h exp=8", pending); end
        n_vec++;
        if (msi_int !== 32'd0) begin n_err++; $display("FAIL basic_early_int got=%h exp=0", msi_int); end
        tick();
        n_vec++;
        if (msi_int !== 32'h8) begin n_err++; $display("FAIL basic_issue got=%h exp=8", msi_int); end
        n_vec++;
        if (busy !== 1'b1 || pending !== 32'd0) begin
            n_err++; $display("FAIL basic_issue_state busy=%b pending=%h exp busy=1 pending=0", busy, pending);
        end
        tick();
        n_vec++;
        if (msi_int !== 32'd0) begin n_err++; $display("FAIL basic_single_cycle got=%h exp=0", msi_int); end
        tick();
        tick();
        sent = 1'b1;
        tick();
        sent = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || pending !== 32'd0) begin
            n_err++; $display("FAIL basic_done busy=%b pending=%h exp busy=0 pending=0", busy, pending);
        end
        wait_msi(10, v, a);
        n_vec++;
        if (v !== 32'd0) begin n_err++; $display("FAIL basic_spurious got=%h exp=0", v); end
    endtask

    task automatic test_fold_rr();
        logic [31:0] v;
        int a0, a1;
        mmen = 12'd1;
        irq  = 32'h0000_000E;
        tick();
        irq = '0;
        n_vec++;
        if (pending !== 32'h3) begin n_err++; $display("FAIL fold_pending got=%h exp=3", pending); end
        wait_msi(8, v, a0);
        n_vec++;
        if (v !== 32'h1) begin n_err++; $display("FAIL fold_first got=%h exp=1", v); end
        ack_sent();
        wait_msi(8, v, a1);
        n_vec++;
        if (v !== 32'h2) begin n_err++; $display("FAIL fold_second got=%h exp=2", v); end
        n_vec++;
        if (a1 - a0 !== 3) begin n_err++; $display("FAIL min_spacing got=%0d exp=3", a1 - a0); end
        ack_sent();
        wait_msi(20, v, a1);
        n_vec++;
        if (v !== 32'd0 || pending !== 32'd0) begin
            n_err++; $display("FAIL fold_drained int=%h pending=%h exp 0 0", v, pending);
        end
    endtask

    task automatic test_fail_retry();
        logic [31:0] v;
        int a, bad;
        mmen = 12'd6;
        irq  = 32'h10;
        tick();
        irq = '0;
        wait_msi(8, v, a);
        n_vec++;
        if (v !== 32'h10) begin n_err++; $display("FAIL retry_first got=%h exp=10", v); end
        tick();
        sent = 1'b1;
        fail = 1'b1;
        tick();
        sent = 1'b0;
        fail = 1'b0;
        n_vec++;
        if (pending !== 32'h10 || busy !== 1'b1) begin
            n_err++; $display("FAIL retry_repend pending=%h busy=%b exp 10 1", pending, busy);
        end
        bad = 0;
        repeat (15) begin
            tick();
            if (busy !== 1'b1 || msi_int !== 32'd0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL backoff_hold bad_cycles=%0d exp=0", bad); end
        tick();
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL backoff_end busy=%b exp=0", busy); end
        tick();
        n_vec++;
        if (msi_int !== 32'h10) begin n_err++; $display("FAIL retry_reissue got=%h exp=10", msi_int); end
        ack_sent();
    endtask

    task automatic test_timeout();
        logic [31:0] v;
        int a0, a1;
        mmen = 12'd5;
        irq  = 32'h40;
        tick();
        irq = '0;
        wait_msi(8, v, a0);
        n_vec++;
        if (v !== 32'h40) begin n_err++; $display("FAIL timeout_first got=%h exp=40", v); end
        wait_msi(200, v, a1);
        n_vec++;
        if (v !== 32'h40) begin n_err++; $display("FAIL timeout_retry got=%h exp=40", v); end
        n_vec++;
        if (a1 - a0 !== 82) begin n_err++; $display("FAIL timeout_delay got=%0d exp=82", a1 - a0); end
        ack_sent();
    endtask

    task automatic test_enable_gating();
        logic [31:0] v;
        int a0, a1, bad;
        en = 4'd0;
        tick();
        tick();
        irq = 32'h1;
        tick();
        irq = '0;
        bad = 0;
        repeat (10) begin
            tick();
            if (msi_int !== 32'd0) bad++;
        end
        n_vec++;
        if (bad !== 0) begin n_err++; $display("FAIL gate_no_issue bad_cycles=%0d exp=0", bad); end
        n_vec++;
        if (pending !== 32'h1 || busy !== 1'b0) begin
            n_err++; $display("FAIL gate_pending pending=%h busy=%b exp 1 0", pending, busy);
        end
        en = 4'd1;
        a0 = cyc_cnt;
        wait_msi(8, v, a1);
        n_vec++;
        if (v !== 32'h1 || a1 - a0 !== 2) begin
            n_err++; $display("FAIL gate_release got=%h after=%0d exp=1 after=2", v, a1 - a0);
        end
        ack_sent();
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] v;
        int a;
        irq = 32'h4;
        tick();
        irq = '0;
        wait_msi(8, v, a);
        n_vec++;
        if (v !== 32'h4) begin n_err++; $display("FAIL rst_wait_issue got=%h exp=4", v); end
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_vec++;
        if (msi_int !== 32'd0 || busy !== 1'b0 || pending !== 32'd0) begin
            n_err++; $display("FAIL rst_wait_clear int=%h busy=%b pending=%h exp 0", msi_int, busy, pending);
        end
        ack_sent();
        tick();
        n_vec++;
        if (msi_int !== 32'd0 || busy !== 1'b0 || pending !== 32'd0) begin
            n_err++; $display("FAIL late_sent int=%h busy=%b pending=%h exp 0", msi_int, busy, pending);
        end
        irq = 32'h81;
        tick();
        irq = '0;
        wait_msi(8, v, a);
        n_vec++;
        if (v !== 32'h1) begin n_err++; $display("FAIL rst_ptr_first got=%h exp=1", v); end
        ack_sent();
        wait_msi(8, v, a);
        n_vec++;
        if (v !== 32'h80) begin n_err++; $display("FAIL rst_ptr_second got=%h exp=80", v); end
        ack_sent();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_fold_rr();
        test_fail_retry();
        test_timeout();
        test_enable_gating();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pcie_us_msi_gen.md
# pcie_us_msi_gen

MSI interrupt generator between the core's interrupt sources and the UltraScale+ PCIe hard block's `cfg_interrupt_msi_*` port for physical function 0. Latches up to 32 interrupt request pulses, folds them onto the vector count granted in `cfg_interrupt_msi_mmenable`, and arbitrates round-robin among them. Issues each MSI as a single-cycle one-hot pulse on `cfg_interrupt_msi_int`. Retries on `fail` or on a response timeout.

## Interface
- `IRQ_COUNT`, 32: number of request inputs (1..32).
- `TIMEOUT`, 4096: cycles to wait for `sent`/`fail` before treating the MSI as failed.
- `BACKOFF`, 16: idle cycles after a failure before the next issue.
- `clk` in 1: PCIe user clock, 250 MHz.
- `rst_n` in 1: synchronous, active-low reset.
- `irq` in IRQ_COUNT: per-source request; a cycle with bit i high is one request on source i.
- `cfg_interrupt_msi_enable` in 4: bit 0 = PF0 MSI enabled.
- `cfg_interrupt_msi_mmenable` in 12: bits [2:0] = log2 of granted vector count for PF0; values above 5 are treated as 5.
- `cfg_interrupt_msi_int` out 32: one-hot issue pulse.
- `cfg_interrupt_msi_sent` in 1: completion pulse from the hard block.
- `cfg_interrupt_msi_fail` in 1: failure pulse from the hard block.
- `cfg_interrupt_msi_select` out 4: constant 0.
- `cfg_interrupt_msi_function_number` out 4: constant 0.
- `cfg_interrupt_msi_attr` out 3: constant 0.
- `cfg_interrupt_msi_tph_present` out 1: constant 0.
- `cfg_interrupt_msi_tph_type` out 2: constant 0.
- `cfg_interrupt_msi_tph_st_tag` out 9: constant 0.
- `cfg_interrupt_msi_pending_status` out 32: constant 0.
- `cfg_interrupt_msi_pending_status_data_enable` out 1: constant 0.
- `cfg_interrupt_msi_pending_status_function_num` out 4: constant 0.
- `pending` out 32: current pending vector bitmap (debug/status).
- `busy` out 1: high in ISSUE, WAIT or BACKOFF.

## Operation
- **Vector count.** N = 1 << min(mmenable[2:0], 5). Source i maps to vector `i & (N-1)`. The folded OR of all requests for a vector sets that vector's `pending` bit.
- **Eligibility.** A vector is eligible when its `pending` bit is set, its index is below N, and `msi_enable[0]` = 1.
- **IDLE.**
  - Any eligible vector: select with the round-robin selector, capture its index in `cur`, clear its `pending` bit, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE.** Drive `msi_int = 1 << cur` for exactly one cycle, load the timeout counter with TIMEOUT-1, then go to WAIT.
- **WAIT.**
  - `sent`: advance the round-robin pointer to (cur+1) mod 32, go to IDLE.
  - `fail`, or the timeout counter reaches 0: set `pending[cur]`, load the backoff counter with BACKOFF-1, go to BACKOFF.
  - If `sent` and `fail` arrive in the same cycle, `fail` wins.
- **BACKOFF.** Count down to 0, then go to IDLE. The round-robin pointer is not advanced, so the failed vector is retried first.
- **Round-robin selection.** The pointer starts at 0. The selector picks the lowest eligible index ≥ pointer, wrapping to index 0 if none is found.
- **Request set vs. clear.** A request arriving in the same cycle as the IDLE→ISSUE clear of that vector sets `pending` again, so it is delivered again later; the set wins. A request during WAIT for `cur` re-pends `cur`.
- **Enable dropped.** If `msi_enable[0]` drops, an in-flight MSI still runs through WAIT normally. Pending bits are retained and no new issue occurs until the enable returns.
- **mmenable shrinks.** Pending bits at or above the new N are retained but are ineligible until N grows again.

## Timing
- **Reset values.** On `rst_n` = 0 at a clock edge:
  - `pending` = 0, pointer = 0, `cur` = 0, state = IDLE.
  - `msi_int` = 0, `busy` = 0, all counters = 0.
  - Reset mid-WAIT discards the in-flight MSI; a late `sent` or `fail` while in IDLE is ignored.
- **Latency.** `irq` at cycle t:
  - `pending` bit set at t+1.
  - IDLE→ISSUE at t+1 (state = ISSUE from t+2).
  - `msi_int` pulse registered and visible during t+2.
- **`msi_int`.** Registered output, never high for two consecutive cycles, never high outside ISSUE.
- **Minimum spacing.** Issue-to-issue spacing is 3 cycles: ISSUE, WAIT with `sent`, IDLE.
- **Timeout.** An MSI with no response is declared failed TIMEOUT cycles after its ISSUE cycle.
- **Counter widths.** `$clog2(TIMEOUT)` and `$clog2(BACKOFF)` bits; counters saturate at 0.

## Structure
- Shared package holds:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, BACKOFF=3);
  - the MSI_VEC_MAX = 32 constant;
  - the mmenable clamp function.
- One sub-module, `pcie_us_msi_rr_sel`: combinational 32-bit round-robin selector.
  - Inputs: request mask, pointer.
  - Outputs: valid, 5-bit index.
- Vector folding, the state machine and the counters stay in the top module.

## Test plan
- **Single-vector basic issue.** mmenable=5, enable=1; pulse `irq[3]` at cycle 10 → `msi_int` = 0x8 during cycle 12 only. `sent` at cycle 15 → `pending` = 0, `busy` low at 16.
- **Folding and round-robin.** mmenable=1 (N=2); pulse `irq` = 0x0000_000E → vectors 0 and 1 pending. Issue order is 0x1 then 0x2, each after `sent`; no further MSI.
- **Fail and retry.** Issue vector 4, answer `fail` → `pending[4]` re-set, `busy` held for BACKOFF=16 cycles, then `msi_int` = 0x10 again.
- **Timeout.** TIMEOUT=64, no response → retry pulse occurs 64+16+2 cycles after the first pulse.
- **Enable gating.** enable=0, pulse `irq[0]` → no MSI, `pending` = 0x1. Raise enable → MSI issues 2 cycles later.
- **Reset mid-WAIT.** Reset during WAIT → all outputs 0. A `sent` pulse after reset changes nothing.
